// File: rtl/frame_capture_packer.sv
// frame_capture_packer: arms on request, locks to the next SOF and packs one frame
// of pixels little-endian into OUT_WIDTH write strobes with line/SOF error flags.
module frame_capture_packer #(
    parameter int PIXEL_WIDTH = 8,
    parameter int OUT_WIDTH   = 32,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   arm,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [PIXEL_WIDTH-1:0] s_data,
    input  logic                   s_sof,
    input  logic                   s_eol,
    output logic                   wr_en,
    output logic [OUT_WIDTH-1:0]   wr_data,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   err_line,
    output logic                   err_sof
);
    localparam int PPW = OUT_WIDTH / PIXEL_WIDTH;
    localparam int KW  = PPW > 1 ? $clog2(PPW) : 1;
    localparam int CW  = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;
    localparam int RW  = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE} state_t;

    state_t               state_q;
    logic [KW-1:0]        k_q, k_eff;
    logic [CW-1:0]        col_q, col_eff;
    logic [RW-1:0]        row_q, row_eff;
    logic [OUT_WIDTH-1:0] pack_q, pack_d, wr_data_q;
    logic                 wr_en_q, frame_done_q, err_line_q, err_sof_q;
    logic                 take, eol_exp, last_slot, last_pix;

    // An SOF beat always restarts position tracking, whether locking or resyncing.
    always_comb begin
        take      = s_valid && (state_q == CAPTURE || (state_q == WAIT_SOF && s_sof));
        k_eff     = s_sof ? '0 : k_q;
        col_eff   = s_sof ? '0 : col_q;
        row_eff   = s_sof ? '0 : row_q;
        pack_d    = pack_q;
        pack_d[int'(k_eff)*PIXEL_WIDTH +: PIXEL_WIDTH] = s_data;
        eol_exp   = col_eff == CW'(IMG_WIDTH - 1);
        last_slot = k_eff == KW'(PPW - 1);
        last_pix  = eol_exp && row_eff == RW'(IMG_HEIGHT - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            col_q        <= '0;
            row_q        <= '0;
            pack_q       <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            err_line_q   <= 1'b0;
            err_sof_q    <= 1'b0;
        end else begin
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            if (state_q == IDLE && arm) begin
                state_q    <= WAIT_SOF;
                err_line_q <= 1'b0;
                err_sof_q  <= 1'b0;
            end
            if (take) begin
                pack_q       <= pack_d;
                k_q          <= last_slot ? '0 : k_eff + 1'b1;
                col_q        <= eol_exp ? '0 : col_eff + 1'b1;
                row_q        <= eol_exp ? row_eff + 1'b1 : row_eff;
                state_q      <= last_pix ? IDLE : CAPTURE;
                frame_done_q <= last_pix;
                if (last_slot) begin
                    wr_en_q   <= 1'b1;
                    wr_data_q <= pack_d;
                end
                if (s_eol != eol_exp) err_line_q <= 1'b1;
                if (state_q == CAPTURE && s_sof) err_sof_q <= 1'b1;
            end
        end
    end

    assign s_ready    = 1'b1;
    assign wr_en      = wr_en_q;
    assign wr_data    = wr_data_q;
    assign busy       = state_q != IDLE;
    assign frame_done = frame_done_q;
    assign err_line   = err_line_q;
    assign err_sof    = err_sof_q;
endmodule

// File: tb/tb_frame_capture_packer.sv
// tb_frame_capture_packer: directed scoreboard bench for a 4x2 frame on 32- and 8-bit builds.
module tb_frame_capture_packer;
    logic        clk = 1'b0, rst_n = 1'b0, arm = 1'b0, arm8 = 1'b0;
    logic        s_valid = 1'b0, s_sof = 1'b0, s_eol = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready, wr_en, busy, frame_done, err_line, err_sof;
    logic [31:0] wr_data;
    logic        s_ready8, wr_en8, busy8, frame_done8, err_line8, err_sof8;
    logic [7:0]  wr_data8;

    typedef struct {logic [31:0] d; bit done; int cyc;} exp_t;
    exp_t q[$], q8[$];
    int   checks = 0, errors = 0, wr_cnt = 0, cyc = 0, n0;

    frame_capture_packer #(.PIXEL_WIDTH(8), .OUT_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(2)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol), .wr_en(wr_en), .wr_data(wr_data),
        .busy(busy), .frame_done(frame_done), .err_line(err_line), .err_sof(err_sof));

    frame_capture_packer #(.PIXEL_WIDTH(8), .OUT_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .arm(arm8), .s_valid(s_valid), .s_ready(s_ready8),
        .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol), .wr_en(wr_en8), .wr_data(wr_data8),
        .busy(busy8), .frame_done(frame_done8), .err_line(err_line8), .err_sof(err_sof8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (wr_en) begin
            wr_cnt++;
            chk("wr_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("wr_data", wr_data, e.d);
                chk("frame_done", 32'(frame_done), 32'(e.done));
                chk("wr_latency", cyc, e.cyc);
            end
        end else chk("done_without_wr", 32'(frame_done), 0);
    end

    always @(negedge clk) begin
        exp_t e;
        if (wr_en8) begin
            chk("wr8_expected", 32'(q8.size() != 0), 1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                chk("wr8_data", 32'(wr_data8), e.d);
                chk("frame_done8", 32'(frame_done8), 32'(e.done));
                chk("wr8_latency", cyc, e.cyc);
            end
        end
    end

    task automatic beat(input logic [7:0] d, input logic sof, input logic eol, input logic a);
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_sof = sof; s_eol = eol; arm = a;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; arm = 1'b0;
        end
    endtask

    task automatic do_arm(input bit to8);
        @(negedge clk);
        s_valid = 1'b0; arm = !to8; arm8 = to8;
        @(negedge clk);
        arm = 1'b0; arm8 = 1'b0;
    endtask

    task automatic frame(input logic [7:0] b, input int gap, input bit bad, input bit e32,
                         input bit e8, input bit arm_last);
        logic [31:0] w;
        for (int i = 0; i < 8; i++) begin
            beat(b + 8'(i), i == 0, bad ? (i == 2 || i == 7) : (i == 3 || i == 7), arm_last && i == 7);
            w[8*(i%4) +: 8] = b + 8'(i);
            if (e32 && i % 4 == 3) q.push_back('{w, i == 7, cyc + 1});
            if (e8) q8.push_back('{32'(b + 8'(i)), i == 7, cyc + 1});
            idle(gap);
        end
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle(2);
        chk("rst_s_ready", 32'(s_ready), 1);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err_line", 32'(err_line), 0);
        chk("rst_err_sof", 32'(err_sof), 0);
        rst_n = 1'b1;
        idle(2);
        n0 = wr_cnt;
        do_arm(0);
        chk("nom_busy_armed", 32'(busy), 1);
        frame(8'h00, 0, 0, 1, 0, 0);
        idle(2);
        chk("nom_q_empty", q.size(), 0);
        chk("nom_wr_cnt", wr_cnt - n0, 2);
        chk("nom_busy_low", 32'(busy), 0);
        chk("nom_err_line", 32'(err_line), 0);
        chk("nom_err_sof", 32'(err_sof), 0);
        n0 = wr_cnt;
        do_arm(0);
        for (int i = 0; i < 3; i++) beat(8'hAA, 1'b0, 1'b0, 1'b0);
        frame(8'h00, 0, 0, 1, 0, 0);
        idle(2);
        chk("lock_wr_cnt", wr_cnt - n0, 2);
        chk("lock_q_empty", q.size(), 0);
        n0 = wr_cnt;
        frame(8'h40, 0, 0, 0, 0, 0);
        idle(2);
        chk("noarm_wr_cnt", wr_cnt - n0, 0);
        do_arm(0);
        frame(8'h00, 2, 0, 1, 0, 0);
        idle(2);
        chk("gap_q_empty", q.size(), 0);
        do_arm(0);
        frame(8'h00, 0, 1, 1, 0, 0);
        idle(2);
        chk("line_err_held", 32'(err_line), 1);
        chk("line_err_sof", 32'(err_sof), 0);
        chk("line_q_empty", q.size(), 0);
        do_arm(0);
        chk("line_err_cleared", 32'(err_line), 0);
        frame(8'h20, 0, 0, 1, 0, 1);
        idle(2);
        chk("armlast_busy", 32'(busy), 0);
        chk("armlast_q_empty", q.size(), 0);
        n0 = wr_cnt;
        frame(8'h30, 0, 0, 0, 0, 0);
        idle(2);
        chk("armlast_ignored", wr_cnt - n0, 0);
        do_arm(0);
        for (int i = 0; i < 5; i++) begin
            beat(8'(i), i == 0, i == 3, 1'b0);
            if (i == 3) q.push_back('{32'h03020100, 1'b0, cyc + 1});
        end
        frame(8'h10, 0, 0, 1, 0, 0);
        idle(2);
        chk("sof_err_sof", 32'(err_sof), 1);
        chk("sof_err_line", 32'(err_line), 0);
        chk("sof_q_empty", q.size(), 0);
        do_arm(0);
        for (int i = 0; i < 3; i++) beat(8'(i), i == 0, 1'b0, 1'b0);
        idle(1);
        chk("rstmid_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_wr_en", 32'(wr_en), 0);
        chk("rstmid_wr_data", wr_data, 0);
        chk("rstmid_done", 32'(frame_done), 0);
        idle(1);
        rst_n = 1'b1;
        n0 = wr_cnt;
        for (int i = 3; i < 8; i++) beat(8'(i), 1'b0, i == 3 || i == 7, 1'b0);
        idle(3);
        chk("rstmid_no_wr", wr_cnt - n0, 0);
        do_arm(1);
        frame(8'h00, 0, 0, 0, 1, 0);
        idle(2);
        chk("w8_q_empty", q8.size(), 0);
        chk("w8_busy", 32'(busy8), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
